// File: rtl/arith_ctrl_pkg.sv
// Shared definitions for the nibble-serial arithmetic controller:
// FSM state encoding and the adder slice width.
package arith_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder built from 1-bit full-adder cells.
module nibble_add4
  import arith_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder: adds two WIDTH-bit operands through a single 4-bit
// adder slice, LSB nibble first, with the carry registered between nibbles.
// Valid/ready request in, valid/ready result out.
// Optional macro NIBBLE_SERIAL_SUB_EN adds in_sub for A-B (B inverted, carry-in 1).
module nibble_serial_add_ctrl
  import arith_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int unsigned NIB  = WIDTH / NIBBLE_W;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    sum_q;
  logic                carry_q;
  logic                cout_q;
  logic [IDXW-1:0]     idx_q;
  logic                sub_mode;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;
  logic                start_carry;

`ifdef NIBBLE_SERIAL_SUB_EN
  logic sub_q;

  // Subtract mode is captured with the operands so later in_sub changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sub_q <= in_sub;
    end
  end

  assign sub_mode    = sub_q;
  assign start_carry = in_sub ? 1'b1 : in_cin;
`else
  assign sub_mode    = 1'b0;
  assign start_carry = in_cin;
`endif

  // Select the current nibble; in subtract mode B is inverted per nibble.
  always_comb begin
    slice_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    slice_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_mode}};
  end

  nibble_add4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept in IDLE, NIB slice cycles in RUN, hold DONE until taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)            state_nxt = RUN;
      RUN:     if (idx_q == LAST_IDX)   state_nxt = DONE;
      DONE:    if (out_ready)           state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Operand capture and per-nibble accumulation of sum and carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            carry_q <= start_carry;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= slice_sum;
          carry_q <= slice_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q <= slice_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16 main instance plus a
// WIDTH=4 instance for the single-nibble case). Expected results come from an
// integer-addition model pushed to a scoreboard queue at request time.
module tb_nibble_serial_add_ctrl;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic          busy;

  logic          w4_in_valid;
  logic          w4_in_ready;
  logic [3:0]    w4_in_a;
  logic [3:0]    w4_in_b;
  logic          w4_in_cin;
  logic          w4_in_sub;
  logic          w4_out_valid;
  logic          w4_out_ready;
  logic [3:0]    w4_out_sum;
  logic          w4_out_cout;
  logic          w4_busy;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef NIBBLE_SERIAL_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w4_in_valid),
    .in_ready  (w4_in_ready),
    .in_a      (w4_in_a),
    .in_b      (w4_in_b),
    .in_cin    (w4_in_cin),
`ifdef NIBBLE_SERIAL_SUB_EN
    .in_sub    (w4_in_sub),
`endif
    .out_valid (w4_out_valid),
    .out_ready (w4_out_ready),
    .out_sum   (w4_out_sum),
    .out_cout  (w4_out_cout),
    .busy      (w4_busy)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    logic [W-1:0] bb;
    bb = b;
    if (sub) return {1'b0, a} + {1'b0, ~bb} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Present one request for one edge and record the expected result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic sub);
    logic [W:0] r;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    r = model(a, b, cin, sub);
    sb.push_back('{sum: r[W-1:0], cout: r[W]});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; lat = edges after the accepting edge.
  task automatic wait_valid(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      lat = k;
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_cout, out_sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_hold: rdy/vld/busy/cout/sum got %b%b%b%b %h want 1000 0000",
               in_ready, out_valid, busy, out_cout, out_sum);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    checks++;
    if ({in_ready, out_valid, busy, out_cout, out_sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_release: rdy/vld/busy/cout/sum got %b%b%b%b %h want 1000 0000",
               in_ready, out_valid, busy, out_cout, out_sum);
    end
  endtask

  task automatic test_basic;
    int   lat;
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    send(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_run_status: busy=%b in_ready=%b want 1 0", busy, in_ready);
    end
    wait_valid(lat, ok);
    checks++;
    if (!ok || lat != 4) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges (valid=%0d) want 4", lat, ok);
    end
    e = sb.pop_front();
    checks++;
    if (out_sum !== 16'h2201 || out_cout !== 1'b0 || out_sum !== e.sum || out_cout !== e.cout) begin
      errors++;
      $display("FAIL basic_result: got %h/%b want %h/%b", out_sum, out_cout, e.sum, e.cout);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_in_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_handshake: vld=%b rdy=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_carry_chain;
    logic [W-1:0] va[3] = '{16'hFFFF, 16'hFFFF, 16'h8000};
    logic [W-1:0] vb[3] = '{16'h0001, 16'hFFFF, 16'h8000};
    logic         vc[3] = '{1'b0, 1'b1, 1'b0};
    int   lat;
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(va[i], vb[i], vc[i], 1'b0);
      wait_valid(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != 4 || out_sum !== e.sum || out_cout !== e.cout) begin
        errors++;
        $display("FAIL carry_chain[%0d]: got %h/%b lat %0d want %h/%b lat 4",
                 i, out_sum, out_cout, lat, e.sum, e.cout);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_pressure;
    int           lat;
    bit           ok;
    exp_t         e;
    logic [W-1:0] s;
    logic         c;
    out_ready = 1'b0;
    send(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    wait_valid(lat, ok);
    checks++;
    if (!ok || lat != 4) begin
      errors++;
      $display("FAIL bp_latency: got %0d (valid=%0d) want 4", lat, ok);
    end
    s = out_sum;
    c = out_cout;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
          out_sum !== s || out_cout !== c) begin
        errors++;
        $display("FAIL bp_stall[%0d]: vld=%b rdy=%b busy=%b sum=%h cout=%b want 1 0 1 %h %b",
                 i, out_valid, in_ready, busy, out_sum, out_cout, s, c);
      end
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    checks++;
    if (out_sum !== e.sum || out_cout !== e.cout) begin
      errors++;
      $display("FAIL bp_result: got %h/%b want %h/%b", out_sum, out_cout, e.sum, e.cout);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_ghost: vld=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_mid_reset;
    int   lat;
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    void'(sb.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, out_cout, out_sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL mid_reset_async: rdy/vld/busy/cout/sum got %b%b%b%b %h want 1000 0000",
               in_ready, out_valid, busy, out_cout, out_sum);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send(16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_valid(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || lat != 4 || out_sum !== 16'h0003 || out_sum !== e.sum || out_cout !== e.cout) begin
      errors++;
      $display("FAIL mid_reset_recover: got %h/%b lat %0d want %h/%b lat 4",
               out_sum, out_cout, lat, e.sum, e.cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_operand_change;
    int   lat;
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    send(16'h3C3C, 16'h4321, 1'b1, 1'b0);
    in_a   = 16'hDEAD;
    in_b   = 16'hBEEF;
    in_cin = 1'b0;
    wait_valid(lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || out_sum !== e.sum || out_cout !== e.cout) begin
      errors++;
      $display("FAIL operand_change: got %h/%b want %h/%b", out_sum, out_cout, e.sum, e.cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int   lat;
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
      end
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
      wait_valid(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || lat != 4 || out_sum !== e.sum || out_cout !== e.cout) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got %h/%b lat %0d want %h/%b lat 4",
                 i, out_sum, out_cout, lat, e.sum, e.cout);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef NIBBLE_SERIAL_SUB_EN
  task automatic test_sub;
    logic [W-1:0] va[2] = '{16'h0005, 16'h0007};
    logic [W-1:0] vb[2] = '{16'h0007, 16'h0005};
    logic [W-1:0] ws[2] = '{16'hFFFE, 16'h0002};
    logic         wc[2] = '{1'b0, 1'b1};
    int   lat;
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send(va[i], vb[i], 1'b0, 1'b1);
      in_sub = 1'b0;
      wait_valid(lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || out_sum !== ws[i] || out_cout !== wc[i] || out_sum !== e.sum || out_cout !== e.cout) begin
        errors++;
        $display("FAIL sub[%0d]: got %h/%b want %h/%b", i, out_sum, out_cout, ws[i], wc[i]);
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  task automatic test_width4;
    logic [3:0] va[2] = '{4'hF, 4'h9};
    logic [3:0] vb[2] = '{4'h1, 4'h3};
    logic       vc[2] = '{1'b0, 1'b1};
    logic [3:0] ws[2] = '{4'h0, 4'hD};
    logic       wc[2] = '{1'b1, 1'b0};
    w4_out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      w4_in_a     = va[i];
      w4_in_b     = vb[i];
      w4_in_cin   = vc[i];
      w4_in_valid = 1'b1;
      @(posedge clk); #1;
      w4_in_valid = 1'b0;
      checks++;
      if (w4_out_valid !== 1'b0 || w4_busy !== 1'b1) begin
        errors++;
        $display("FAIL w4_run[%0d]: vld=%b busy=%b want 0 1", i, w4_out_valid, w4_busy);
      end
      @(posedge clk); #1;
      checks++;
      if (w4_out_valid !== 1'b1 || w4_out_sum !== ws[i] || w4_out_cout !== wc[i]) begin
        errors++;
        $display("FAIL w4_result[%0d]: vld=%b got %h/%b want 1 %h/%b",
                 i, w4_out_valid, w4_out_sum, w4_out_cout, ws[i], wc[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_cin       = 1'b0;
    in_sub       = 1'b0;
    out_ready    = 1'b1;
    w4_in_valid  = 1'b0;
    w4_in_a      = '0;
    w4_in_b      = '0;
    w4_in_cin    = 1'b0;
    w4_in_sub    = 1'b0;
    w4_out_ready = 1'b1;
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_pressure();
    test_mid_reset();
    test_operand_change();
    test_back_to_back();
`ifdef NIBBLE_SERIAL_SUB_EN
    test_sub();
`endif
    test_width4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
